// File: rtl/pool2x2_stream_if.sv
// Stream-side bundle for pool2x2_stream: frame control,
// pixel input handshake and pooled-result output handshake.
interface pool2x2_stream_if #(
  parameter int DATA_W = 32
);

  logic              start;
  logic              mode;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output mode,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  mode,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output busy,
    output done
  );

endinterface

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 average/max pooling over a raster
// feature map, with a one-row line buffer and registered output.
module pool2x2_stream #(
  parameter int DATA_W = 32,
  parameter int FM_W   = 6,
  parameter int FM_H   = 6
) (
  input  logic              clk,
  input  logic              rst,
  pool2x2_stream_if.slave   bus
);

  localparam int CW    = (FM_W > 1) ? $clog2(FM_W) : 1;
  localparam int RW    = (FM_H > 1) ? $clog2(FM_H) : 1;
  localparam int N_OUT = (FM_W / 2) * (FM_H / 2);
  localparam int NW    = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [NW-1:0] cnt_q;
  logic          mode_q;

  logic signed [DATA_W-1:0] lbuf [FM_W];
  logic signed [DATA_W-1:0] hold_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;

  logic in_ready;
  logic busy;
  logic done;

  logic xfer;
  logic hs;
  logic col_last;
  logic row_last;
  logic win;
  logic start_ok;

  logic [CW-1:0] col_m1;

  logic signed [DATA_W-1:0] pix;
  logic signed [DATA_W-1:0] pa;
  logic signed [DATA_W-1:0] pb;
  logic signed [DATA_W-1:0] pc;
  logic signed [DATA_W+1:0] sum;
  logic signed [DATA_W-1:0] avg;
  logic signed [DATA_W-1:0] mx_top;
  logic signed [DATA_W-1:0] mx_bot;
  logic signed [DATA_W-1:0] mx;
  logic signed [DATA_W-1:0] res;

  assign pix      = $signed(bus.in_data);
  assign xfer     = bus.in_valid && in_ready;
  assign hs       = out_valid_q && bus.out_ready;
  assign col_last = (col_q == CW'(FM_W - 1));
  assign row_last = (row_q == RW'(FM_H - 1));
  assign start_ok = (state_q == S_IDLE) && bus.start;
  assign col_m1   = col_q - CW'(1);

  // Odd row, odd col closes a window; odd edge pixels never match.
  assign win = xfer && row_q[0] && col_q[0];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer && col_last && row_last)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid_q || bus.out_ready)
          state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = !(out_valid_q && !bus.out_ready);
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 1'b0;
    end else if (start_ok) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= bus.mode;
    end else if (xfer) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if (hs) begin
      cnt_q <= cnt_q + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_FIN) begin
      assert (cnt_q == NW'(N_OUT));
    end
  end

  // ---------------- pixel storage ----------------
  // Storage is not reset: every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if (xfer && !row_q[0]) begin
      lbuf[col_q] <= pix;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && row_q[0] && !col_q[0]) begin
      hold_q <= pix;
    end
  end

  // ---------------- window math ----------------
  assign pa = lbuf[col_m1];
  assign pb = lbuf[col_q];
  assign pc = hold_q;

  always_comb begin
    sum = (DATA_W+2)'(pa) + (DATA_W+2)'(pb)
        + (DATA_W+2)'(pc) + (DATA_W+2)'(pix);
    avg = DATA_W'(sum >>> 2);
  end

  always_comb begin
    mx_top = (pa > pb) ? pa : pb;
    mx_bot = (pc > pix) ? pc : pix;
    mx     = (mx_top > mx_bot) ? mx_top : mx_bot;
    res    = mode_q ? mx : avg;
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (win) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res;
    end else if (hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: window vector table on a 2x2 map,
// directed 6x6/5x5 frames, backpressure, reset abort, random frames.
module tb_pool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start6, start5, start2;
  logic        mode;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  int          sel;

  logic        s_in_ready, s_out_valid;
  logic        s_busy, s_done;
  logic [31:0] s_out_data;

  int n_chk  = 0;
  int n_fail = 0;
  int got[$];
  int done_cnt = 0;
  int acc = 0;

  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_data = '0;

  pool2x2_stream_if #(.DATA_W(32)) if6 ();
  pool2x2_stream_if #(.DATA_W(32)) if5 ();
  pool2x2_stream_if #(.DATA_W(32)) if2 ();

  assign if6.start = start6;
  assign if5.start = start5;
  assign if2.start = start2;
  assign if6.mode = mode;
  assign if5.mode = mode;
  assign if2.mode = mode;
  assign if6.in_data = in_data;
  assign if5.in_data = in_data;
  assign if2.in_data = in_data;
  assign if6.in_valid = in_valid;
  assign if5.in_valid = in_valid;
  assign if2.in_valid = in_valid;
  assign if6.out_ready = out_ready;
  assign if5.out_ready = out_ready;
  assign if2.out_ready = out_ready;

  pool2x2_stream #(.DATA_W(32), .FM_W(6), .FM_H(6))
    u6 (.clk(clk), .rst(rst), .bus(if6));
  pool2x2_stream #(.DATA_W(32), .FM_W(5), .FM_H(5))
    u5 (.clk(clk), .rst(rst), .bus(if5));
  pool2x2_stream #(.DATA_W(32), .FM_W(2), .FM_H(2))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  always_comb begin
    case (sel)
      0: begin
        s_in_ready  = if6.in_ready;
        s_out_valid = if6.out_valid;
        s_out_data  = if6.out_data;
        s_busy      = if6.busy;
        s_done      = if6.done;
      end
      1: begin
        s_in_ready  = if5.in_ready;
        s_out_valid = if5.out_valid;
        s_out_data  = if5.out_data;
        s_busy      = if5.busy;
        s_done      = if5.done;
      end
      default: begin
        s_in_ready  = if2.in_ready;
        s_out_valid = if2.out_valid;
        s_out_data  = if2.out_data;
        s_busy      = if2.busy;
        s_done      = if2.done;
      end
    endcase
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Output monitor: stalled results must stay put.
  always @(negedge clk) begin
    if (!rst && !prev_rst && prev_stall) begin
      chk("stall_valid", longint'(s_out_valid), 1);
      chk("stall_data", longint'($signed(s_out_data)),
          longint'($signed(prev_data)));
    end
    if (!rst) begin
      if (s_out_valid && out_ready)
        got.push_back(int'(s_out_data));
      if (s_done) done_cnt++;
      if (in_valid && s_in_ready) acc++;
    end
    prev_stall <= s_out_valid && !out_ready;
    prev_data  <= s_out_data;
    prev_rst   <= rst;
  end

  // Reference: pooled value per 2x2 tile with plain arithmetic.
  function automatic void model(input int pix[$], input int w,
                                input int h, input bit m,
                                output int q[$]);
    longint v[4];
    longint s, f, best;
    q = {};
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        v[0] = pix[(2*r)*w + 2*c];
        v[1] = pix[(2*r)*w + 2*c + 1];
        v[2] = pix[(2*r+1)*w + 2*c];
        v[3] = pix[(2*r+1)*w + 2*c + 1];
        if (m) begin
          best = v[0];
          for (int k = 1; k < 4; k++)
            if (v[k] > best) best = v[k];
          q.push_back(int'(best));
        end else begin
          s = v[0] + v[1] + v[2] + v[3];
          f = s / 4;
          if (s < 0 && (s % 4) != 0) f = f - 1;
          q.push_back(int'(f));
        end
      end
    end
  endfunction

  task automatic pulse_start(input int s, input bit m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = m;
    start6 = (s == 0);
    start5 = (s == 1);
    start2 = (s == 2);
    @(posedge clk); #1;
    start6 = 1'b0;
    start5 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic run_frame(input int s, input bit m,
                           input int pix[$], input int exp_q[$],
                           input int rdy, input int vld,
                           input bit stall1, input string tag);
    int idx = 0;
    int post = 0;
    int stall_left = stall1 ? 5 : 0;
    bit keep = 0;
    bit seen = 0;
    bit fin = 0;
    bit stall_now = 0;
    logic [31:0] held = '0;
    int n = pix.size();
    sel = s;
    got = {};
    done_cnt = 0;
    acc = 0;
    pulse_start(s, m);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mode = 1'($urandom);
      if (idx < n) begin
        in_data  = pix[idx];
        in_valid = keep ? 1'b1 : ($urandom_range(99) < vld);
      end else begin
        in_data  = $urandom;
        in_valid = 1'b1;
      end
      if (stall_left > 0 && s_out_valid) begin
        if (stall_left == 5) held = s_out_data;
        out_ready = 1'b0;
        stall_left--;
        stall_now = 1;
      end else begin
        out_ready = ($urandom_range(99) < rdy);
        stall_now = 0;
      end
      @(negedge clk);
      if (stall_now) begin
        chk({tag, "_stall_ready"}, longint'(s_in_ready), 0);
        chk({tag, "_stall_out"}, longint'($signed(s_out_data)),
            longint'($signed(held)));
      end
      keep = in_valid && !s_in_ready && (idx < n);
      if (in_valid && s_in_ready && idx < n) idx++;
      if (s_done) seen = 1;
      if (seen) post++;
      if (post >= 3) begin
        fin = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_finished"}, longint'(fin), 1);
    chk({tag, "_busy_after"}, longint'(s_busy), 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_inputs"}, acc, n);
    chk({tag, "_n_out"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_out%0d", tag, i), got[i], exp_q[i]);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  typedef struct {
    bit m;
    int p[4];
    int e;
  } vec_t;

  vec_t tbl[10];
  int   seq[$];
  int   ex[$];
  int   idx;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, '{-1, -2, -3, -4}, -3};
    tbl[1] = '{1'b1, '{-1, -2, -3, -4}, -1};
    tbl[2] = '{1'b0, '{32'h7FFFFFFF, 32'h7FFFFFFF,
                       32'h7FFFFFFF, 32'h7FFFFFFF}, 32'h7FFFFFFF};
    tbl[3] = '{1'b0, '{32'h80000000, 32'h80000000,
                       32'h80000000, 32'h80000000}, 32'h80000000};
    tbl[4] = '{1'b0, '{1, 1, 1, 0}, 0};
    tbl[5] = '{1'b0, '{-1, 0, 0, 0}, -1};
    tbl[6] = '{1'b1, '{5, -7, 100, -100}, 100};
    tbl[7] = '{1'b0, '{5, -7, 100, -100}, -1};
    tbl[8] = '{1'b1, '{32'h7FFFFFFF, 32'h80000000, 0, 1},
               32'h7FFFFFFF};
    tbl[9] = '{1'b0, '{32'h7FFFFFFF, 32'h80000000, 0, 1}, 0};

    rst = 1'b1;
    start6 = 1'b0;
    start5 = 1'b0;
    start2 = 1'b0;
    mode = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst%0d_out_valid", s), longint'(s_out_valid), 0);
      chk($sformatf("rst%0d_in_ready", s), longint'(s_in_ready), 0);
      chk($sformatf("rst%0d_busy", s), longint'(s_busy), 0);
      chk($sformatf("rst%0d_done", s), longint'(s_done), 0);
      chk($sformatf("rst%0d_out_data", s), longint'(s_out_data), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      seq = {};
      for (int k = 0; k < 4; k++) seq.push_back(tbl[i].p[k]);
      ex = {tbl[i].e};
      run_frame(2, tbl[i].m, seq, ex, 100, 100, 0,
                $sformatf("vec%0d", i));
    end

    seq = {};
    for (int i = 0; i < 36; i++) seq.push_back(i);
    ex = {3, 5, 7, 15, 17, 19, 27, 29, 31};
    run_frame(0, 1'b0, seq, ex, 100, 100, 0, "avg6");
    ex = {7, 9, 11, 19, 21, 23, 31, 33, 35};
    run_frame(0, 1'b1, seq, ex, 100, 100, 0, "max6");
    ex = {3, 5, 7, 15, 17, 19, 27, 29, 31};
    run_frame(0, 1'b0, seq, ex, 100, 100, 1, "stall6");

    seq = {};
    for (int i = 0; i < 25; i++) seq.push_back(i);
    ex = {3, 5, 13, 15};
    run_frame(1, 1'b0, seq, ex, 100, 100, 0, "avg5");

    // Abort a frame after ten pixels, then demand a fresh start.
    sel = 0;
    done_cnt = 0;
    acc = 0;
    pulse_start(0, 1'b0);
    idx = 0;
    for (int c = 0; c < 200 && acc < 10; c++) begin
      in_valid = 1'b1;
      in_data = idx;
      out_ready = 1'b1;
      @(negedge clk);
      if (in_valid && s_in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("abort_inputs", acc, 10);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", longint'(s_out_valid), 0);
    chk("abort_busy", longint'(s_busy), 0);
    chk("abort_in_ready", longint'(s_in_ready), 0);
    chk("abort_done", longint'(s_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("nostart_in_ready", longint'(s_in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("abort_no_done", done_cnt, 0);
    seq = {};
    for (int i = 0; i < 36; i++) seq.push_back(i);
    ex = {3, 5, 7, 15, 17, 19, 27, 29, 31};
    run_frame(0, 1'b0, seq, ex, 100, 100, 0, "after_abort");

    for (int t = 0; t < 12; t++) begin
      int s = $urandom_range(2);
      int w = (s == 0) ? 6 : (s == 1) ? 5 : 2;
      bit m = 1'($urandom);
      seq = {};
      for (int i = 0; i < w * w; i++) begin
        if (t % 2 == 0) seq.push_back(int'($urandom));
        else seq.push_back(int'($urandom_range(200)) - 100);
      end
      model(seq, w, w, m, ex);
      run_frame(s, m, seq, ex, $urandom_range(100, 30),
                $urandom_range(100, 30), 1'($urandom),
                $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pool2x2_stream.md
POOL2X2_STREAM -- requirements
Module: pool2x2_stream

Interface
REQ-001 Parameter DATA_W, default 32: signed pixel width.
REQ-002 Parameter FM_W, default 6: input feature-map width in pixels, 2..64.
REQ-003 Parameter FM_H, default 6: input feature-map height in pixels, 2..64.
REQ-004 Port clk  input  1: single clock; all logic SHALL be rising-edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: one-cycle request to begin a frame; honoured only in IDLE.
REQ-007 Port mode  input  1: 0 = average pool, 1 = max pool; sampled when start is accepted.
REQ-008 Port in_data  input  DATA_W: signed pixel, raster order (row-major, row 0 first).
REQ-009 Port in_valid  input  1: in_data is valid.
REQ-010 Port in_ready  output  1: block accepts in_data this cycle.
REQ-011 Port out_data  output  DATA_W: signed pooled result, raster order.
REQ-012 Port out_valid  output  1: out_data is valid.
REQ-013 Port out_ready  input  1: downstream accepts out_data.
REQ-014 Port busy  output  1: high from accepted start until done.
REQ-015 Port done  output  1: one-cycle pulse at end of frame.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN and FIN.
- IDLE -> RUN on start; mode is latched, and row/col counters and output count clear.
- RUN -> DRAIN when the last input pixel (FM_H-1, FM_W-1) is accepted.
- DRAIN -> FIN when out_valid is low or an out_valid&&out_ready handshake occurs.
- FIN -> IDLE after one cycle.
REQ-017 An input transfer SHALL occur when in_valid && in_ready; otherwise the pixel is held upstream.
REQ-018 in_ready SHALL equal (state==RUN) && !(out_valid && !out_ready).
REQ-019 The col counter SHALL advance on each transfer and wrap at FM_W-1 to 0, incrementing row.
REQ-020 A one-row line buffer of FM_W entries SHALL store even-row pixels; a horizontal register SHALL hold the even-column pixel of the current odd row.
REQ-021 A 2x2 window SHALL complete when the transfer is at odd row and odd col; the result SHALL be formed from buf[col-1], buf[col], the held pixel and in_data.
REQ-022 Avg mode: the sum SHALL be computed at DATA_W+2 bits, sign-extended, then arithmetically shifted right by 2 (floor), and truncated to DATA_W bits.
REQ-023 Max mode: the result SHALL be the signed maximum of the four pixels.
REQ-024 The result SHALL be registered: out_valid rises in the cycle after the completing transfer (latency 1).
REQ-025 out_data and out_valid SHALL hold stable until out_ready; out_valid clears on handshake unless a new result loads in the same cycle.
REQ-026 Odd FM_W SHALL drop the last column; odd FM_H SHALL drop the last row; those pixels are still consumed.
REQ-027 The output count SHALL be (FM_W/2)*(FM_H/2), integer division.
REQ-028 done SHALL pulse high during FIN only; busy SHALL be high in RUN and DRAIN.
REQ-029 start asserted outside IDLE SHALL be ignored.
REQ-030 A mode change outside IDLE SHALL have no effect on the current frame.
REQ-031 in_valid SHALL be ignored in IDLE, DRAIN and FIN.

Reset
REQ-032 On rst, state SHALL be IDLE; row, col and the output counter SHALL be 0.
REQ-033 On rst, out_valid, in_ready, busy and done SHALL be 0, and out_data SHALL be 0.
REQ-034 rst asserted mid-frame SHALL abort the frame without a done pulse; line-buffer contents need not be cleared.
REQ-035 After reset deasserts, the block SHALL require a new start.

Verification
REQ-036 Avg, 6x6, pixels 0..35, out_ready=1 -> outputs 3,5,7,15,17,19,27,29,31; done pulses once.
REQ-037 Max, 6x6, pixels 0..35 -> outputs 7,9,11,19,21,23,31,33,35.
REQ-038 Avg, window {-1,-2,-3,-4} -> output -3 (floor of -10/4); window {0x7FFFFFFF x4} -> 0x7FFFFFFF.
REQ-039 out_ready held low for 5 cycles after the first result -> in_ready drops, out_data stable, no data lost; the full 9-output sequence still matches.
REQ-040 FM_W=5, FM_H=5, avg, pixels 0..24 -> 4 outputs 3,5,13,15; all 25 inputs accepted; done asserts.
REQ-041 rst asserted after 10 input pixels -> outputs idle next cycle, no done; a following start+full frame yields the correct 9 outputs.
